led_mode_ctl: RTL
=================

Name: led_mode_ctl

Overview:
Pushbutton front end that drives the red_en/green_en inputs of the blinky LED stage. Synchronizes and debounces a raw active-low button, classifies short and long presses, and steps a 2-bit colour mode. Sits directly upstream of blinky, in the same 24 MHz clock domain. All outputs are registered.

Parameters:
DEBOUNCE_CYCLES, 480_000, consecutive stable cycles required to accept a button level change (20 ms @ 24 MHz); must be >= 2.
LONG_CYCLES, 24_000_000, cycles a debounced press must be held to count as long (1 s); must be > DEBOUNCE_CYCLES.
RESET_MODE, 2'd1, mode loaded on reset.
AUTO_CYCLES, 48_000_000, auto-advance period; used only when LED_MODE_AUTO_EN is defined.

Ports:
clk  in  1  system clock, 24 MHz
reset_n  in  1  asynchronous active-low reset
btn_n  in  1  raw pushbutton, active-low, asynchronous to clk
red_en  out  1  to blinky red_en
green_en  out  1  to blinky green_en
mode  out  2  current mode: 0 OFF, 1 GREEN, 2 RED, 3 BOTH
mode_chg  out  1  one-cycle pulse in the first cycle a new mode value is visible

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n): assertion clears state immediately; release is sampled on clk.
- Reset values: mode=RESET_MODE, red_en=RESET_MODE[1], green_en=RESET_MODE[0], mode_chg=0, synchronizer flops=1 (released), stable=released, counters=0, FSM=IDLE.
- Sync: two-flop synchronizer on btn_n; pressed = ~sync2.
- Debounce: counter clears whenever pressed==stable. When they differ, counter increments. When counter reaches DEBOUNCE_CYCLES-1 while they still differ, stable flips on that edge and counter clears. Any glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Edge events: press_evt = stable 0->1; release_evt = stable 1->0; each lasts one cycle.
- FSM:
  IDLE: press_evt -> HELD; hold counter cleared.
  HELD: hold counter increments each cycle.
    release_evt before count reaches LONG_CYCLES-1 -> short press: mode <= mode+1 (wraps 3->0); -> IDLE.
    Count reaches LONG_CYCLES-1 -> long press: mode <= 0 (OFF); -> LONGHELD.
  LONGHELD: release_evt -> IDLE; no mode change.
- Mode update lands one edge after the FSM event cycle. red_en=mode[1] and green_en=mode[0] update on the same edge. mode_chg pulses on that edge only when the value actually changes (a long press while already OFF gives no pulse).
- Latency: raw release to mode change = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Hold counter saturates in LONGHELD and never wraps.
- If reset_n is asserted mid-press, state returns to reset values. After release, a still-held button must be re-debounced (press_evt fires) but produces no mode change until its release.
- Widths: counters are $clog2(param)+1 bits; all arithmetic is unsigned.

Optional Feature:
LED_MODE_AUTO_EN
- Defined: an auto timer runs in IDLE while mode!=OFF. On reaching AUTO_CYCLES-1, mode advances 1->2->3->1 (skips OFF), with a mode_chg pulse, and the timer clears. The timer clears on press_evt and is held at 0 outside IDLE or while mode==OFF.
- Undefined: no timer logic; mode changes only on button events. Port list is identical in both builds.

Test Plan:
(all cases use DEBOUNCE_CYCLES=4, LONG_CYCLES=40, AUTO_CYCLES=100, RESET_MODE=1)
1. Reset: hold reset_n=0 with btn_n toggling -> mode=1, green_en=1, red_en=0, mode_chg=0. Release reset -> outputs unchanged.
2. Short press: btn_n low for 10 cycles, then high -> mode goes 1->2 exactly 7 cycles after the rising btn_n; red_en=1, green_en=0; mode_chg high for 1 cycle. Three more short presses -> 3, 0, 1 (wrap).
3. Glitch: btn_n low pulses of 1, 2 and 3 cycles -> stable never flips; no mode change, no mode_chg.
4. Long press: from mode=3, hold btn_n low 60 cycles -> mode=0 while still held (about 46 cycles after the falling btn_n); release -> mode stays 0. Repeat the long press from 0 -> no mode_chg.
5. Reset mid-press: btn_n low, pulse reset_n low at cycle 20, keep btn_n low 30 more cycles, then release -> mode returns to 1 at reset; the release after reset causes no mode change.
6. LED_MODE_AUTO_EN build: idle from mode=1 -> mode 2 at 100 cycles, 3 at 200, 1 at 300. From mode=0 -> stays 0 indefinitely. A short press at cycle 50 restarts the auto timer.

Source files
------------

// File: rtl/led_mode_ctl.sv
// Pushbutton front end for blinky: sync, debounce, short/long press classification, 2-bit colour mode.
// Define LED_MODE_AUTO_EN to add the idle auto-advance timer (port list is the same either way).
module led_mode_ctl #(
   parameter int unsigned DEBOUNCE_CYCLES = 480_000,
   parameter int unsigned LONG_CYCLES     = 24_000_000,
   parameter logic [1:0]  RESET_MODE      = 2'd1,
   parameter int unsigned AUTO_CYCLES     = 48_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_n,
   output logic       red_en,
   output logic       green_en,
   output logic [1:0] mode,
   output logic       mode_chg
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || AUTO_CYCLES < 2) begin : g_bad_params
      $error("led_mode_ctl: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, HELD, LONGHELD} state_t;

   logic              sync1, sync2;
   logic [1:0]        warm;
   logic              armed;
   logic              pressed, sync_ok;
   logic              stable, stable_d;
   logic [DB_W-1:0]   db_cnt;
   logic              press_evt, release_evt;
   logic              auto_fire;
   state_t            state, state_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [1:0]        mode_nxt;

   assign pressed = ~sync2;
   assign sync_ok = warm[1];

   // A press already held across reset is ignored until the button has been seen released once;
   // warm masks the two cycles in which the synchronizer still shows its reset value.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         warm  <= '0;
         armed <= 1'b0;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         warm  <= {warm[0], 1'b1};
         if (sync_ok && !pressed) armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable   <= 1'b0;
         stable_d <= 1'b0;
         db_cnt   <= '0;
      end else begin
         stable_d <= stable;
         if (pressed == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            stable <= pressed;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign press_evt   =  stable & ~stable_d;
   assign release_evt = ~stable &  stable_d;

`ifdef LED_MODE_AUTO_EN
   localparam int AUTO_W = $clog2(AUTO_CYCLES) + 1;
   localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);

   logic [AUTO_W-1:0] auto_cnt, auto_nxt;

   always_comb begin
      auto_nxt  = '0;
      auto_fire = 1'b0;
      if (state == IDLE && mode != 2'd0 && !press_evt) begin
         if (auto_cnt == AUTO_LAST) auto_fire = 1'b1;
         else                       auto_nxt  = auto_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) auto_cnt <= '0;
      else          auto_cnt <= auto_nxt;
   end
`else
   assign auto_fire = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      mode_nxt  = mode;
      case (state)
         IDLE: begin
            hold_nxt = '0;
            if (press_evt) begin
               state_nxt = armed ? HELD : LONGHELD;
            end else if (auto_fire) begin
               mode_nxt = (mode == 2'd3) ? 2'd1 : mode + 2'd1;
            end
         end
         HELD: begin
            // Reaching the long threshold wins over a release seen in the same cycle.
            if (hold_cnt == HOLD_LAST) begin
               mode_nxt  = 2'd0;
               state_nxt = LONGHELD;
            end else if (release_evt) begin
               mode_nxt  = mode + 2'd1;
               state_nxt = IDLE;
            end else begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         LONGHELD: begin
            if (release_evt) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         hold_cnt <= '0;
         mode     <= RESET_MODE;
         red_en   <= RESET_MODE[1];
         green_en <= RESET_MODE[0];
         mode_chg <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         mode     <= mode_nxt;
         red_en   <= mode_nxt[1];
         green_en <= mode_nxt[0];
         mode_chg <= (mode_nxt != mode);
      end
   end

endmodule
